// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/DMA arbiter for a single synchronous RAM (IDLE -> GRANT -> DATA).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default is fixed CPU priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpu_cmd,
  input  logic [8:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [8:0]  dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        grant_dma
);
  typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;
  state_t r_state;
  logic r_rd;
  logic w_cpu_v, w_req, w_pick_dma;
  logic [1:0] w_cmd;
  assign w_cpu_v = cpu_cmd == 2'b01 || cpu_cmd == 2'b10;
  assign w_req = w_cpu_v || dma_req;
`ifdef MEM_ARB_RR_EN
  logic r_last_dma;
  assign w_pick_dma = dma_req && (!w_cpu_v || !r_last_dma);
`else
  assign w_pick_dma = dma_req && !w_cpu_v;
`endif
  assign w_cmd = w_pick_dma ? (dma_write ? 2'b10 : 2'b01) : cpu_cmd;
  // mem_* registers double as the capture registers: loaded on entry to GRANT, cleared on exit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rd      <= 1'b0;
      mem_cmd   <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ready <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      busy      <= 1'b0;
      grant_dma <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_dma <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_state   <= GRANT;
          busy      <= 1'b1;
          grant_dma <= w_pick_dma;
          r_rd      <= w_cmd == 2'b01;
          mem_cmd   <= w_cmd;
          mem_addr  <= w_pick_dma ? dma_addr : cpu_addr;
          mem_wdata <= w_pick_dma ? dma_wdata : cpu_wdata;
`ifdef MEM_ARB_RR_EN
          r_last_dma <= w_pick_dma;
`endif
        end
        GRANT: begin
          r_state   <= DATA;
          mem_cmd   <= 2'b00;
          mem_addr  <= '0;
          mem_wdata <= '0;
          cpu_ready <= !grant_dma;
          dma_ack   <= grant_dma;
        end
        DATA: begin
          r_state   <= IDLE;
          busy      <= 1'b0;
          cpu_ready <= 1'b0;
          dma_ack   <= 1'b0;
          if (r_rd && grant_dma) dma_rdata <= mem_rdata;
          if (r_rd && !grant_dma) cpu_rdata <= mem_rdata;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] cpu_cmd = '0;
  logic [8:0] cpu_addr = '0, dma_addr = '0;
  logic [15:0] cpu_wdata = '0, dma_wdata = '0;
  logic dma_req = 1'b0, dma_write = 1'b0;
  logic [15:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic cpu_ready, dma_ack, busy, grant_dma;
  logic [1:0] mem_cmd;
  logic [8:0] mem_addr;
  int n_chk = 0, n_fail = 0;
  logic [15:0] ram [512];
  logic [511:0] ram_wr = '0;
  logic [15:0] m_ram [512];
  logic [15:0] m_cpu_rd, m_dma_rd;
  logic m_last_dma, m_gdma;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_dma(grant_dma)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [8:0] a);
    return a == 9'h005 ? 16'hBEEF : 16'hA5C3 ^ {a[6:0], a};
  endfunction

  always @(posedge clk) begin
    if (mem_cmd == 2'b01) mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    if (mem_cmd == 2'b10) begin
      ram[mem_addr] <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pending();
    return cpu_cmd == 2'b01 || cpu_cmd == 2'b10 || dma_req;
  endfunction

  task automatic do_reset();
    reset = 1'b1; cpu_cmd = 2'b00; dma_req = 1'b0; dma_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem", {mem_cmd, mem_addr, mem_wdata}, 0);
    check("rst_flags", {busy, grant_dma, cpu_ready, dma_ack}, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    reset = 1'b0;
    m_last_dma = 1'b1; m_gdma = 1'b0; m_cpu_rd = '0; m_dma_rd = '0;
  endtask

  task automatic idle_check();
    check("i_mem", {mem_cmd, mem_addr, mem_wdata}, 0);
    check("i_flags", {busy, cpu_ready, dma_ack}, 0);
    check("i_gdma", grant_dma, m_gdma);
    check("i_cpu_rdata", cpu_rdata, m_cpu_rd);
    check("i_dma_rdata", dma_rdata, m_dma_rd);
  endtask

  // Called at the falling edge of an IDLE cycle with a request present; returns at the DATA falling edge.
  task automatic serve(input bit wd, output bit got_dma, output bit pd);
    bit cv;
    logic [1:0] c;
    logic [8:0] a;
    logic [15:0] w;
    cv = cpu_cmd == 2'b01 || cpu_cmd == 2'b10;
    pd = dma_req && (!cv || (RR && !m_last_dma));
    m_last_dma = pd;
    m_gdma = pd;
    c = pd ? (dma_write ? 2'b10 : 2'b01) : cpu_cmd;
    a = pd ? dma_addr : cpu_addr;
    w = pd ? dma_wdata : cpu_wdata;
    @(negedge clk);
    check("g_cmd", mem_cmd, c);
    check("g_addr", mem_addr, a);
    check("g_wdata", mem_wdata, w);
    check("g_busy", busy, 1);
    check("g_gdma", grant_dma, pd);
    check("g_rdy", {cpu_ready, dma_ack}, 0);
    if (wd) begin
      if (pd) begin dma_req = 1'b0; dma_addr = 9'($urandom); dma_wdata = 16'($urandom); end
      else begin cpu_cmd = 2'b00; cpu_addr = 9'($urandom); cpu_wdata = 16'($urandom); end
    end
    if (c == 2'b10) m_ram[a] = w;
    @(negedge clk);
    check("d_rdy", {cpu_ready, dma_ack}, pd ? 2'b01 : 2'b10);
    check("d_mem", {mem_cmd, mem_addr, mem_wdata}, 0);
    check("d_busy", busy, 1);
    check("d_gdma", grant_dma, pd);
    got_dma = dma_ack;
    if (c == 2'b01 && pd) m_dma_rd = m_ram[a];
    if (c == 2'b01 && !pd) m_cpu_rd = m_ram[a];
  endtask

  task automatic rand_cpu();
    cpu_cmd = 2'($urandom_range(0, 3));
    cpu_addr = ($urandom % 2) ? 9'($urandom_range(0, 15)) : 9'($urandom);
    cpu_wdata = 16'($urandom);
  endtask

  task automatic rand_dma();
    dma_req = 1'($urandom % 2);
    dma_write = 1'($urandom % 2);
    dma_addr = ($urandom % 2) ? 9'($urandom_range(0, 15)) : 9'($urandom);
    dma_wdata = 16'($urandom);
  endtask

  initial begin
    bit got, pd;
    logic [3:0] order;
    for (int i = 0; i < 512; i++) m_ram[i] = init_val(9'(i));
    do_reset();
    cpu_cmd = 2'b01; cpu_addr = 9'h005;
    serve(1'b0, got, pd);
    cpu_cmd = 2'b00;
    @(negedge clk);
    idle_check();
    check("cpu_rd_beef", cpu_rdata, 16'hBEEF);
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 9'h1FF; dma_wdata = 16'h1234;
    serve(1'b0, got, pd);
    dma_req = 1'b0;
    @(negedge clk);
    idle_check();
    check("ram_1ff", ram[511], 16'h1234);
    check("cpu_rd_kept", cpu_rdata, 16'hBEEF);
    dma_req = 1'b1; dma_write = 1'b0;
    serve(1'b0, got, pd);
    dma_req = 1'b0;
    @(negedge clk);
    idle_check();
    check("dma_rd_1ff", dma_rdata, 16'h1234);
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 9'h003;
    @(negedge clk);
    check("ab_grant_cmd", mem_cmd, 2'b01);
    reset = 1'b1; dma_req = 1'b0;
    @(negedge clk);
    check("ab_ack", dma_ack, 0);
    check("ab_mem", {mem_cmd, busy}, 0);
    check("ab_rdata", dma_rdata, 0);
    reset = 1'b0;
    m_last_dma = 1'b1; m_gdma = 1'b0; m_cpu_rd = '0; m_dma_rd = '0;
    @(negedge clk);
    idle_check();
    cpu_cmd = 2'b01; cpu_addr = 9'h005;
    serve(1'b1, got, pd);
    repeat (3) begin
      @(negedge clk);
      idle_check();
    end
    do_reset();
    cpu_cmd = 2'b01; cpu_addr = 9'h010; dma_req = 1'b1; dma_write = 1'b1; dma_addr = 9'h011;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, got, pd);
      order[i] = got;
      if (pd) begin dma_write = ~dma_write; dma_addr = 9'($urandom_range(0, 15)); dma_wdata = 16'($urandom); end
      else begin cpu_cmd = ($urandom % 2) ? 2'b01 : 2'b10; cpu_addr = 9'($urandom_range(0, 15)); cpu_wdata = 16'($urandom); end
      @(negedge clk);
      idle_check();
    end
    check("tie_order", order, RR ? 4'b1010 : 4'b0000);
    cpu_cmd = 2'b00;
    repeat (400) begin
      idle_check();
      if (!pending()) begin
        rand_cpu();
        rand_dma();
        if (!pending()) @(negedge clk);
      end else begin
        serve(($urandom % 8) == 0, got, pd);
        if (pd) rand_dma(); else rand_cpu();
        @(negedge clk);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
